memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Sequences a single-port, fixed-latency unified memory shared between the fetch stage (instruction reads) and the memory stage (data reads/writes) of the five-stage pipeline. It owns one outstanding memory transaction at a time, grants the data requester by priority with an alternation rule against fetch starvation, and returns read data with a one-cycle ready pulse. Fetch transactions can be cancelled on a branch flush. The block sits between the FetchStage/MemoryStage modules and the memory macro; requesters stall on `req & ~ready`.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `MEM_LATENCY`, 4, memory access cycles (≥1); address/control must be held for this many cycles
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch read request, held until `if_ready`
- `if_addr`  in  ADDR_W  fetch address, stable while `if_req`
- `if_cancel`  in  1  branch flush; discard pending/in-flight fetch
- `if_ready`  out  1  one-cycle pulse: `if_data` valid
- `if_data`  out  DATA_W  registered fetch read data
- `dm_req`  in  1  data request, held until `dm_ready`
- `dm_we`  in  1  1 = write, 0 = read
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  write data
- `dm_ready`  out  1  one-cycle pulse: read data valid / write done
- `dm_rdata`  out  DATA_W  registered data read result
- `mem_en`  out  1  memory access active
- `mem_wr`  out  1  memory write strobe
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid in last access cycle
- `busy`  out  1  transaction in flight

## Operation
- States: IDLE, IF_ACC, DM_ACC. All outputs except the stall terms used by the requesters are registered.
- In IDLE, arbitration occurs each cycle. Requesters are eligible as follows:
  - `dm_req` is eligible unless `dm_ready` is high this cycle.
  - `if_req` is eligible unless `if_ready` or `if_cancel` is high this cycle.
- Priority:
  - Data wins by default.
  - Fetch wins if both are eligible and the last completed grant was data (`last_dm` flag).
  - `last_dm` resets to 0.
- On a grant, capture the address, `dm_we`, and `dm_wdata` into holding registers, load the counter with 0, and enter IF_ACC or DM_ACC.
- In ACC states:
  - `mem_en` = 1, with `mem_addr`/`mem_wr`/`mem_wdata` driven from the holding registers.
  - `mem_wr` is 1 only for a DM write.
  - The counter increments each cycle.
  - When the counter reaches MEM_LATENCY-1, capture `mem_rdata` into `if_data` or `dm_rdata` (DM reads only; writes leave `dm_rdata` unchanged), update `last_dm`, and return to IDLE.
- Ready pulse:
  - `if_ready`/`dm_ready` goes high for exactly one cycle, the first IDLE cycle after the access.
  - Arbitration in that same cycle excludes the completing requester.
- Cancel:
  - `if_cancel` in IF_ACC sets `cancel_flag`. The access still runs to completion because memory cannot abort.
  - At completion, `if_data` is updated but `if_ready` is suppressed, and `cancel_flag` clears.
  - `if_cancel` in DM_ACC has no effect.
- Requests arriving during ACC wait in IDLE arbitration; they are not queued internally.
- Reset values: state IDLE, counter 0, `last_dm` 0, `cancel_flag` 0, `if_ready`/`dm_ready`/`mem_en`/`mem_wr`/`busy` 0, `mem_addr`/`mem_wdata`/`if_data`/`dm_rdata` 0.
- Reset mid-transaction abandons the access immediately: `mem_en` drops asynchronously and no ready pulse is produced.
- Requester stall terms are combinational in the requester: `if_stall = if_req & ~if_ready`, and `dm_stall` likewise.

## Timing
- Uncontended request seen at cycle 0:
  - `mem_en` high in cycles 1..MEM_LATENCY.
  - Ready pulses at cycle MEM_LATENCY+1.
  - With the default latency, ready arrives at cycle 5.
- Back-to-back transactions: the next grant is decided in the ready cycle, and its `mem_en` starts the following cycle. That gives one idle memory cycle between accesses and a throughput of one access per MEM_LATENCY+1 cycles.
- `busy` = state ≠ IDLE and is registered with the state.
- MEM_LATENCY = 1: a single `mem_en` cycle; capture and the return to IDLE happen in that same cycle.
- Counter width is $clog2(MEM_LATENCY+1). The counter never wraps because it is reloaded at grant.
- Simultaneous `if_req` and `dm_req` with `last_dm` = 0: data is granted, fetch is granted next. Two consecutive data grants occur only if fetch is not eligible.

## Test plan
- **Uncontended fetch:** `if_req` at cycle 0 with `if_addr`=0x0010 and memory word 0xA5A5. Required: `mem_en` cycles 1–4 with `mem_addr`=0x0010, `if_ready` pulse at cycle 5, `if_data`=0xA5A5.
- **Data write then read:**
  - `dm_we`=1, `dm_addr`=0x0200, `dm_wdata`=0x1234. Required: `mem_wr`=1 for 4 cycles, then `dm_ready`.
  - Then a read of 0x0200. Required: `dm_rdata`=0x1234, `mem_wr`=0 throughout.
- **Simultaneous requests from reset:** `if_req` and `dm_req` both at cycle 0. Required:
  - DM granted first, with `dm_ready` at cycle 5.
  - IF granted at cycle 5, with `mem_en` in cycles 6–9 and `if_ready` at cycle 10.
- **Continuous data plus fetch:** `dm_req` held for 3 transactions with `if_req` held. Required: grants alternate DM, IF, DM, IF; fetch is never denied twice in a row.
- **Cancel:** `if_cancel` at cycle 2 of an IF access. Required:
  - `mem_en` still completes 4 cycles.
  - No `if_ready` is produced.
  - A pending `dm_req` is granted in the first IDLE cycle.
- **Reset mid-transaction:** `rst` asserted during DM_ACC cycle 2. Required:
  - `mem_en`, `mem_wr` and `busy` drop to 0 immediately, with no ready pulse.
  - After release, a new `if_req` completes with normal 5-cycle latency.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// memory_arbiter bus bundle: fetch port, data port and memory macro side.
// slave is the arbiter view; master is the requester/memory view.
interface memory_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_cancel;
  logic              if_ready;
  logic [DATA_W-1:0] if_data;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ready;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, if_cancel,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_ready, if_data,
    output dm_ready, dm_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output if_req, if_addr, if_cancel,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_ready, if_data,
    input  dm_ready, dm_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/memory_arbiter.sv
// Single-port fixed-latency memory arbiter between fetch and data stages.
// One access in flight; data has priority, alternating to avoid fetch starvation.
module memory_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = 4
) (
  input logic            clk,
  input logic            rst,
  memory_arbiter_if.slave bus
);
  localparam int            CW   = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    IF_ACC,
    DM_ACC
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last_dm_q, last_dm_d;
  logic              cancel_q, cancel_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic              busy_q, busy_d;

  logic dm_elig;
  logic if_elig;
  logic grant_if;
  logic grant_dm;
  logic done;

  // A requester being handed its ready pulse sits out this arbitration.
  assign dm_elig  = bus.dm_req & ~dm_ready_q;
  assign if_elig  = bus.if_req & ~if_ready_q & ~bus.if_cancel;
  assign grant_if = if_elig & (~dm_elig | last_dm_q);
  assign grant_dm = dm_elig & ~grant_if;
  assign done     = (cnt_q == LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_dm_d  = last_dm_q;
    cancel_d   = cancel_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_data_d  = if_data_q;
    dm_rdata_d = dm_rdata_q;
    if_ready_d = 1'b0;
    dm_ready_d = 1'b0;
    mem_en_d   = mem_en_q;
    mem_wr_d   = mem_wr_q;
    busy_d     = busy_q;

    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          grant_if: begin
            state_d = IF_ACC;
            addr_d  = bus.if_addr;
          end
          grant_dm: begin
            state_d = DM_ACC;
            addr_d  = bus.dm_addr;
          end
          default: ;
        endcase
        if (grant_if | grant_dm) begin
          cnt_d    = '0;
          cancel_d = 1'b0;
          we_d     = grant_dm & bus.dm_we;
          wdata_d  = bus.dm_wdata;
          mem_en_d = 1'b1;
          mem_wr_d = grant_dm & bus.dm_we;
          busy_d   = 1'b1;
        end
      end
      IF_ACC, DM_ACC: begin
        cnt_d = cnt_q + 1'b1;
        if (state_q == IF_ACC && bus.if_cancel) begin
          cancel_d = 1'b1;
        end
        if (done) begin
          state_d  = IDLE;
          cancel_d = 1'b0;
          mem_en_d = 1'b0;
          mem_wr_d = 1'b0;
          busy_d   = 1'b0;
          if (state_q == IF_ACC) begin
            // Flushed fetches still land in if_data but stay silent.
            if_data_d  = bus.mem_rdata;
            if_ready_d = ~(cancel_q | bus.if_cancel);
            last_dm_d  = 1'b0;
          end else begin
            if (!we_q) begin
              dm_rdata_d = bus.mem_rdata;
            end
            dm_ready_d = 1'b1;
            last_dm_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_dm_q  <= 1'b0;
      cancel_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_data_q  <= '0;
      dm_rdata_q <= '0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_dm_q  <= last_dm_d;
      cancel_q   <= cancel_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_data_q  <= if_data_d;
      dm_rdata_q <= dm_rdata_d;
      if_ready_q <= if_ready_d;
      dm_ready_q <= dm_ready_d;
      mem_en_q   <= mem_en_d;
      mem_wr_q   <= mem_wr_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.if_ready  = if_ready_q;
  assign bus.if_data   = if_data_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;

  a_rdy_excl: assert property (@(posedge clk) disable iff (rst)
    !(if_ready_q && dm_ready_q));
  a_wr_en: assert property (@(posedge clk) disable iff (rst)
    mem_wr_q |-> mem_en_q);
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios then random traffic,
// all checked against a transaction-window reference model.
module tb_memory_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int L  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  memory_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .MEM_LATENCY(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [15:0] mem    [256];
  logic [15:0] refmem [256];
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int          m_own = 0;
  int          m_g   = 0;
  logic [15:0] m_addr = '0;
  logic [15:0] m_wd   = '0;
  bit          m_we = 0, m_cancel = 0, m_last_dm = 0;
  bit          e_if_rdy = 0, e_dm_rdy = 0;
  logic [15:0] e_if_data = '0, e_dm_rdata = '0;

  int if_todo = 0, dm_todo = 0;
  int if_rc, dm_rc, if_cnt, dm_cnt, en_cnt, wr_cnt;
  int seq[$];
  int s;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_cancel = 0; m_last_dm = 0;
    e_if_rdy = 0; e_dm_rdy = 0;
    e_if_data = '0; e_dm_rdata = '0;
  endtask

  task automatic clr_obs();
    if_rc = -1; dm_rc = -1; if_cnt = 0; dm_cnt = 0;
    en_cnt = 0; wr_cnt = 0;
    seq.delete();
  endtask

  // Grant decision for the current cycle from present inputs.
  task automatic decide();
    bit dm_el, if_el;
    if (m_own == 1 && cyc >= m_g + 1 && cyc <= m_g + L && bus.if_cancel)
      m_cancel = 1;
    if (m_own == 0) begin
      dm_el = bus.dm_req && !e_dm_rdy;
      if_el = bus.if_req && !e_if_rdy && !bus.if_cancel;
      if (if_el && (!dm_el || m_last_dm)) begin
        m_own = 1; m_g = cyc; m_addr = bus.if_addr;
        m_we = 0; m_cancel = 0;
      end else if (dm_el) begin
        m_own = 2; m_g = cyc; m_addr = bus.dm_addr;
        m_we = bus.dm_we; m_wd = bus.dm_wdata; m_cancel = 0;
      end
    end
  endtask

  // Completion takes effect in the cycle after the last access cycle.
  task automatic advance();
    e_if_rdy = 0; e_dm_rdy = 0;
    if (m_own != 0 && cyc == m_g + L + 1) begin
      if (m_own == 1) begin
        e_if_data = refmem[m_addr[7:0]];
        e_if_rdy  = !m_cancel;
        m_last_dm = 0;
      end else begin
        if (m_we) refmem[m_addr[7:0]] = m_wd;
        else e_dm_rdata = refmem[m_addr[7:0]];
        e_dm_rdy  = 1;
        m_last_dm = 1;
      end
      m_own = 0;
    end
  endtask

  task automatic check_out();
    bit en;
    en = (m_own != 0) && (cyc >= m_g + 1) && (cyc <= m_g + L);
    chk("mem_en", bus.mem_en, en);
    chk("busy", bus.busy, en);
    chk("mem_wr", bus.mem_wr, en && m_we);
    if (en) chk("mem_addr", bus.mem_addr, m_addr);
    if (en && m_we) chk("mem_wdata", bus.mem_wdata, m_wd);
    chk("if_ready", bus.if_ready, e_if_rdy);
    chk("dm_ready", bus.dm_ready, e_dm_rdy);
    chk("if_data", bus.if_data, e_if_data);
    chk("dm_rdata", bus.dm_rdata, e_dm_rdata);
  endtask

  task automatic new_dm();
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'($urandom_range(1));
    bus.dm_addr  = 16'($urandom);
    bus.dm_wdata = 16'($urandom);
  endtask

  task automatic step();
    decide();
    if (bus.mem_en && bus.mem_wr) mem[bus.mem_addr[7:0]] = bus.mem_wdata;
    @(posedge clk);
    #1;
    cyc++;
    advance();
    check_out();
    if (bus.if_ready) begin if_rc = cyc; if_cnt++; seq.push_back(1); end
    if (bus.dm_ready) begin dm_rc = cyc; dm_cnt++; seq.push_back(2); end
    if (bus.mem_en) en_cnt++;
    if (bus.mem_wr) wr_cnt++;
    bus.if_cancel = 1'b0;
    if (e_if_rdy) begin
      if_todo--;
      if (if_todo > 0) bus.if_addr = 16'($urandom);
      else bus.if_req = 1'b0;
    end
    if (e_dm_rdy) begin
      dm_todo--;
      if (dm_todo > 0) new_dm();
      else bus.dm_req = 1'b0;
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.if_cancel = 1'b0;
    if_todo = 0; dm_todo = 0;
    model_reset();
    cyc = 0;
    clr_obs();
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_cancel = 1'b0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      refmem[i] = mem[i];
    end
    mem[8'h10] = 16'hA5A5;
    refmem[8'h10] = 16'hA5A5;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_ready", bus.if_ready, 0);
    chk("rst_dm_ready", bus.dm_ready, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_if_data", bus.if_data, 0);
    chk("rst_dm_rdata", bus.dm_rdata, 0);
    do_reset();

    // uncontended fetch
    bus.if_req = 1'b1; bus.if_addr = 16'h0010; if_todo = 1;
    s = cyc;
    run(7);
    chk("t1_if_lat", if_rc - s, L + 1);
    chk("t1_if_data", bus.if_data, 16'hA5A5);
    chk("t1_en_cnt", en_cnt, L);

    // data write then read
    clr_obs();
    bus.dm_req = 1'b1; bus.dm_we = 1'b1;
    bus.dm_addr = 16'h0200; bus.dm_wdata = 16'h1234; dm_todo = 1;
    s = cyc;
    run(7);
    chk("t2_wr_cnt", wr_cnt, L);
    chk("t2_wr_lat", dm_rc - s, L + 1);
    clr_obs();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0200; dm_todo = 1;
    s = cyc;
    run(7);
    chk("t2_rd_data", bus.dm_rdata, 16'h1234);
    chk("t2_rd_wr_cnt", wr_cnt, 0);
    chk("t2_rd_lat", dm_rc - s, L + 1);

    // simultaneous requests from reset
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 16'h0010; if_todo = 1;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0200; dm_todo = 1;
    run(12);
    chk("t3_dm_rdy_cyc", dm_rc, L + 1);
    chk("t3_if_rdy_cyc", if_rc, 2 * L + 2);
    chk("t3_en_cnt", en_cnt, 2 * L);
    chk("t3_order", (seq.size() == 2) ? seq[0] * 10 + seq[1] : 0, 21);

    // continuous data plus fetch
    clr_obs();
    bus.if_req = 1'b1; bus.if_addr = 16'h0010; if_todo = 3;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0200; dm_todo = 3;
    run(34);
    chk("t4_count", seq.size(), 6);
    for (int i = 0; i < 6 && i < seq.size(); i++)
      chk("t4_alt", seq[i], (i % 2 == 0) ? 2 : 1);

    // cancel during fetch access with a waiting data request
    clr_obs();
    bus.if_req = 1'b1; bus.if_addr = 16'h0010; if_todo = 1;
    s = cyc;
    step();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0200; dm_todo = 1;
    step();
    bus.if_cancel = 1'b1; bus.if_req = 1'b0; if_todo = 0;
    run(11);
    chk("t5_if_rdy_cnt", if_cnt, 0);
    chk("t5_dm_lat", dm_rc - s, 2 * L + 2);
    chk("t5_en_cnt", en_cnt, 2 * L);
    chk("t5_if_data", bus.if_data, 16'hA5A5);

    // reset in the middle of a data write
    clr_obs();
    bus.dm_req = 1'b1; bus.dm_we = 1'b1;
    bus.dm_addr = 16'h0200; bus.dm_wdata = 16'h1234; dm_todo = 1;
    run(2);
    chk("t6_pre_en", bus.mem_en, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_mem_en", bus.mem_en, 0);
    chk("t6_mem_wr", bus.mem_wr, 0);
    chk("t6_busy", bus.busy, 0);
    do_reset();
    chk("t6_dm_ready", bus.dm_ready, 0);
    bus.if_req = 1'b1; bus.if_addr = 16'h0010; if_todo = 1;
    s = cyc;
    run(7);
    chk("t6_if_lat", if_rc - s, L + 1);
    chk("t6_dm_rdy_cnt", dm_cnt, 0);

    // random traffic with flushes
    for (int i = 0; i < 3000; i++) begin
      if (!bus.if_req && $urandom_range(3) == 0) begin
        bus.if_req = 1'b1;
        bus.if_addr = 16'($urandom);
        if_todo = $urandom_range(1, 3);
      end else if (bus.if_req && $urandom_range(15) == 0) begin
        bus.if_cancel = 1'b1;
        bus.if_req = 1'b0;
        if_todo = 0;
      end
      if (!bus.dm_req && $urandom_range(3) == 0) begin
        new_dm();
        dm_todo = $urandom_range(1, 3);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
